// File: rtl/hold_level_pkg.sv
// Shared types and constants for the hold-level driver and its debouncing receiver.
// Both sides take DEFAULT_N from here so their hold times agree.
package hold_level_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_e;

  // Wide enough to hold N itself, so the count never wraps.
  function automatic int timer_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-time counter shared by the HOLD and PULSE states of hold_level_driver.
// load presets the count to 1, clr presets it to 0, en advances it; done flags count == N-1.
module hold_timer
  import hold_level_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int TW = timer_width(N);
  localparam logic [TW-1:0] LAST = TW'(N - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = TW'(1);
    end else if (clr) begin
      timer_d = '0;
    end else if (en && (timer_q != LAST)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign done = (timer_q == LAST);

endmodule

// File: rtl/hold_level_driver.sv
// Drives a level line so every level is held at least N clocks; optional N-cycle
// pulse requests are enabled by defining HOLD_PULSE_EN.
module hold_level_driver
  import hold_level_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter bit INIT = 1'b0,
  parameter int CW   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_level,
`ifdef HOLD_PULSE_EN
  input  logic          req_pulse,
`endif
  output logic          req_ready,
  output logic          line_out,
  output logic          busy,
  output logic [CW-1:0] trans_cnt
);

  state_e        state_q;
  state_e        state_d;
  logic          line_q;
  logic          line_d;
  logic [CW-1:0] trans_q;
  logic [CW-1:0] trans_d;
  logic          t_load;
  logic          t_clr;
  logic          t_en;
  logic          t_done;

  hold_timer #(
    .N(N)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .load (t_load),
    .clr  (t_clr),
    .en   (t_en),
    .done (t_done)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    t_load  = 1'b0;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef HOLD_PULSE_EN
          // Pulse starts its count at 0 so the pulsed level is held a full N cycles.
          if (req_pulse) begin
            line_d  = ~line_q;
            t_clr   = 1'b1;
            state_d = PULSE;
          end else
`endif
          if (req_level != line_q) begin
            line_d  = req_level;
            t_load  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (t_done) begin
          t_clr   = 1'b1;
          state_d = IDLE;
        end else begin
          t_en = 1'b1;
        end
      end
`ifdef HOLD_PULSE_EN
      PULSE: begin
        if (t_done) begin
          line_d  = ~line_q;
          t_load  = 1'b1;
          state_d = HOLD;
        end else begin
          t_en = 1'b1;
        end
      end
`endif
      default: begin
        t_clr   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Every change of the line counts once; a pulse therefore counts twice.
  always_comb begin
    trans_d = trans_q;
    if ((line_d != line_q) && (trans_q != '1)) begin
      trans_d = trans_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= INIT;
      trans_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      trans_q <= trans_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign line_out  = line_q;
  assign trans_cnt = trans_q;

endmodule

// File: tb/tb_hold_level_driver.sv
// Directed bench for hold_level_driver (N=8, INIT=0, CW=16); pulse test runs when HOLD_PULSE_EN is defined.
module tb_hold_level_driver;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_level;
`ifdef HOLD_PULSE_EN
  logic        req_pulse;
`endif
  logic        req_ready;
  logic        line_out;
  logic        busy;
  logic [15:0] trans_cnt;

  int checks;
  int errors;
  int cyc;

  hold_level_driver #(
    .N   (8),
    .INIT(1'b0),
    .CW  (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_level(req_level),
`ifdef HOLD_PULSE_EN
    .req_pulse(req_pulse),
`endif
    .req_ready(req_ready),
    .line_out (line_out),
    .busy     (busy),
    .trans_cnt(trans_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic apply_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++;
    if (line_out !== 1'b0) begin errors++; $display("FAIL reset_line: got %b want 0", line_out); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (trans_cnt !== 16'd0) begin errors++; $display("FAIL reset_trans: got %0d want 0", trans_cnt); end
    $display("test_reset: line=%b ready=%b busy=%b trans=%0d", line_out, req_ready, busy, trans_cnt);
  endtask

  task automatic test_level_change();
    int low_cnt;
    bit line_ok;
    req_valid = 1'b1;
    req_level = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (line_out !== 1'b1) begin errors++; $display("FAIL level_line: got %b want 1", line_out); end
    checks++;
    if (trans_cnt !== 16'd1) begin errors++; $display("FAIL level_trans: got %0d want 1", trans_cnt); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL level_busy: got %b want 1", busy); end
    low_cnt = 0;
    line_ok = 1'b1;
    while (req_ready !== 1'b1 && low_cnt < 40) begin
      if (line_out !== 1'b1) line_ok = 1'b0;
      low_cnt++;
      @(negedge clock);
    end
    checks++;
    if (low_cnt != 7) begin errors++; $display("FAIL level_ready_low: got %0d cycles want 7", low_cnt); end
    checks++;
    if (!line_ok) begin errors++; $display("FAIL level_hold: line dropped during hold, want steady 1"); end
    $display("test_level_change: ready low %0d cycles, line=%b trans=%0d", low_cnt, line_out, trans_cnt);
  endtask

  task automatic test_back_to_back();
    logic lv [3];
    int   t_acc [3];
    int   guard;
    bit   was_ready;
    lv[0] = 1'b1; lv[1] = 1'b0; lv[2] = 1'b1;
    apply_reset(2);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_level = lv[k];
      guard = 0;
      was_ready = 1'b0;
      while (!was_ready && guard < 40) begin
        was_ready = (req_ready === 1'b1);
        @(posedge clock);
        guard++;
        if (!was_ready) @(negedge clock);
      end
      t_acc[k] = cyc;
      @(negedge clock);
      checks++;
      if (line_out !== lv[k]) begin errors++; $display("FAIL b2b_line%0d: got %b want %b", k, line_out, lv[k]); end
      $display("test_back_to_back: req %0d level=%b accepted at cycle %0d", k, lv[k], t_acc[k]);
    end
    req_valid = 1'b0;
    checks++;
    if (t_acc[1] - t_acc[0] != 8) begin errors++; $display("FAIL b2b_gap01: got %0d want 8", t_acc[1] - t_acc[0]); end
    checks++;
    if (t_acc[2] - t_acc[1] != 8) begin errors++; $display("FAIL b2b_gap12: got %0d want 8", t_acc[2] - t_acc[1]); end
    checks++;
    if (trans_cnt !== 16'd3) begin errors++; $display("FAIL b2b_trans: got %0d want 3", trans_cnt); end
  endtask

  task automatic test_reset_in_hold();
    apply_reset(2);
    req_valid = 1'b1;
    req_level = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (line_out !== 1'b1) begin errors++; $display("FAIL rih_start_line: got %b want 1", line_out); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (line_out !== 1'b0) begin errors++; $display("FAIL rih_line: got %b want 0", line_out); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rih_ready: got %b want 1", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rih_busy: got %b want 0", busy); end
    checks++;
    if (trans_cnt !== 16'd0) begin errors++; $display("FAIL rih_trans: got %0d want 0", trans_cnt); end
    $display("test_reset_in_hold: line=%b ready=%b busy=%b trans=%0d", line_out, req_ready, busy, trans_cnt);
  endtask

  task automatic test_no_change();
    req_valid = 1'b1;
    req_level = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL nochg_ready: got %b want 1", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nochg_busy: got %b want 0", busy); end
    checks++;
    if (line_out !== 1'b0) begin errors++; $display("FAIL nochg_line: got %b want 0", line_out); end
    checks++;
    if (trans_cnt !== 16'd0) begin errors++; $display("FAIL nochg_trans: got %0d want 0", trans_cnt); end
    $display("test_no_change: line=%b ready=%b trans=%0d", line_out, req_ready, trans_cnt);
  endtask

`ifdef HOLD_PULSE_EN
  task automatic test_pulse();
    int high_cnt;
    int low_cnt;
    req_valid = 1'b1;
    req_pulse = 1'b1;
    req_level = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_pulse = 1'b0;
    high_cnt = 0;
    low_cnt  = 0;
    while (req_ready !== 1'b1 && low_cnt < 60) begin
      if (line_out === 1'b1) high_cnt++;
      low_cnt++;
      @(negedge clock);
    end
    checks++;
    if (high_cnt != 8) begin errors++; $display("FAIL pulse_high: got %0d cycles want 8", high_cnt); end
    checks++;
    if (low_cnt != 15) begin errors++; $display("FAIL pulse_ready_low: got %0d cycles want 15", low_cnt); end
    checks++;
    if (line_out !== 1'b0) begin errors++; $display("FAIL pulse_end_line: got %b want 0", line_out); end
    checks++;
    if (trans_cnt !== 16'd2) begin errors++; $display("FAIL pulse_trans: got %0d want 2", trans_cnt); end
    $display("test_pulse: high %0d cycles, ready low %0d cycles, trans=%0d", high_cnt, low_cnt, trans_cnt);
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_level = 1'b0;
`ifdef HOLD_PULSE_EN
    req_pulse = 1'b0;
`endif
    test_reset();
    test_level_change();
    test_back_to_back();
    test_reset_in_hold();
    test_no_change();
`ifdef HOLD_PULSE_EN
    test_pulse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
